// File: rtl/ovl_sem_time_stim.sv
// Stimulus generator for ovl_time checker wrappers: start_event pulses, each followed by a
// NUM_CKS-cycle test_expr window with optional single-cycle fault, plus a golden expect_fire.
module ovl_sem_time_stim #(
  parameter int unsigned NUM_CKS     = 2,
  parameter int unsigned GAP_CKS     = 1,
  parameter int unsigned NUM_WINDOWS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       fault_en,
  input  logic [3:0] fault_cycle,
  output logic       start_event,
  output logic       test_expr,
  output logic       in_window,
  output logic       expect_fire,
  output logic [7:0] win_count,
  output logic       done
);

  localparam logic [3:0] NumCks = 4'(NUM_CKS);
  localparam logic [3:0] GapCks = 4'(GAP_CKS);
  localparam logic [7:0] NumWin = 8'(NUM_WINDOWS);

  typedef enum logic [2:0] {
    StIdle,
    StGap,
    StStart,
    StWindow,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic [3:0] k_q, k_d;
  logic [7:0] win_count_q, win_count_d;
  logic       fault_on_q, fault_on_d;
  logic [3:0] fault_cyc_q, fault_cyc_d;

  logic start_event_q, start_event_d;
  logic test_expr_q, test_expr_d;
  logic in_window_q, in_window_d;
  logic expect_fire_q, expect_fire_d;
  logic done_q, done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      gap_q         <= '0;
      k_q           <= '0;
      win_count_q   <= '0;
      fault_on_q    <= 1'b0;
      fault_cyc_q   <= '0;
      start_event_q <= 1'b0;
      test_expr_q   <= 1'b1;
      in_window_q   <= 1'b0;
      expect_fire_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      k_q           <= k_d;
      win_count_q   <= win_count_d;
      fault_on_q    <= fault_on_d;
      fault_cyc_q   <= fault_cyc_d;
      start_event_q <= start_event_d;
      test_expr_q   <= test_expr_d;
      in_window_q   <= in_window_d;
      expect_fire_q <= expect_fire_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    k_d         = k_q;
    win_count_d = win_count_q;
    fault_on_d  = fault_on_q;
    fault_cyc_d = fault_cyc_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StGap;
          gap_d   = GapCks;
        end
      end
      StGap: begin
        // enable low freezes the countdown in place
        if (enable) begin
          if (gap_q <= 4'd1) begin
            state_d = StStart;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
      end
      StStart: begin
        fault_on_d  = fault_en && (fault_cycle != 4'd0) && (fault_cycle <= NumCks);
        fault_cyc_d = fault_cycle;
        k_d         = 4'd1;
        state_d     = StWindow;
      end
      StWindow: begin
        if (k_q >= NumCks) begin
          win_count_d = (win_count_q == 8'hFF) ? 8'hFF : win_count_q + 8'd1;
          fault_on_d  = 1'b0;
          if (win_count_d == NumWin) begin
            state_d = StDone;
          end else begin
            state_d = StGap;
            gap_d   = GapCks;
          end
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from next state so every port comes straight off a flop.
  always_comb begin
    start_event_d = (state_d == StStart);
    in_window_d   = (state_d == StWindow);
    test_expr_d   = !(in_window_d && fault_on_d && (k_d == fault_cyc_d));
    expect_fire_d = in_window_q && !test_expr_q;
    done_d        = (state_d == StDone);
  end

  assign start_event = start_event_q;
  assign test_expr   = test_expr_q;
  assign in_window   = in_window_q;
  assign expect_fire = expect_fire_q;
  assign win_count   = win_count_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ovl_sem_time_stim.sv
// Randomized bench for ovl_sem_time_stim against a timeline-position reference model.
module tb_ovl_sem_time_stim;

  localparam int NumCks = 2;
  localparam int GapCks = 1;
  localparam int NumWin = 4;
  localparam int Period = GapCks + 1 + NumCks;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       fault_en;
  logic [3:0] fault_cycle;
  logic       start_event, test_expr, in_window, expect_fire, done;
  logic [7:0] win_count;

  int n_checks = 0;
  int n_errors = 0;

  ovl_sem_time_stim #(
    .NUM_CKS    (NumCks),
    .GAP_CKS    (GapCks),
    .NUM_WINDOWS(NumWin)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .fault_en   (fault_en),
    .fault_cycle(fault_cycle),
    .start_event(start_event),
    .test_expr  (test_expr),
    .in_window  (in_window),
    .expect_fire(expect_fire),
    .win_count  (win_count),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int cyc, input logic [7:0] got,
                          input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Model: position within one period (gap cycles, then start, then window cycles).
  bit m_idle, m_done;
  int m_pos, m_cnt, m_fault;
  bit e_start, e_test, e_win, e_fire, e_done;

  task automatic model_step(input bit rst, input bit en, input bit fen, input int fc);
    bit pw, pt;
    int p;
    pw = e_win;
    pt = e_test;
    if (rst) begin
      m_idle = 1; m_done = 0; m_pos = 0; m_cnt = 0; m_fault = 0;
      e_fire = 0;
    end else begin
      p = m_pos;
      if (m_done) begin
      end else if (m_idle) begin
        if (en) begin m_idle = 0; m_pos = 0; end
      end else if (p < GapCks) begin
        if (en) m_pos = p + 1;
      end else if (p == GapCks) begin
        m_fault = (fen && fc >= 1 && fc <= NumCks) ? fc : 0;
        m_pos = p + 1;
      end else if (p < Period - 1) begin
        m_pos = p + 1;
      end else begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (m_cnt == NumWin) m_done = 1;
        else m_pos = 0;
      end
      e_fire = pw && !pt;
    end
    e_start = !m_idle && !m_done && m_pos == GapCks;
    e_win   = !m_idle && !m_done && m_pos > GapCks;
    e_test  = !(e_win && (m_pos - GapCks) == m_fault);
    e_done  = m_done;
  endtask

  int done_run;

  initial begin
    reset = 1'b1; enable = 1'b0; fault_en = 1'b0; fault_cycle = 4'd0;
    e_win = 0; e_test = 1;
    done_run = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc < 2) begin
        reset = 1'b1;
      end else begin
        reset = (done_run > 3) || ($urandom_range(0, 99) < 2);
        enable = ($urandom_range(0, 9) != 0);
        // occasional long pauses
        if ((cyc / 40) % 5 == 3 && (cyc % 40) < 6) enable = 1'b0;
        fault_en = $urandom_range(0, 1) == 1;
        fault_cycle = 4'($urandom_range(0, 3));
      end
      @(posedge clock);
      model_step(reset, enable, fault_en, int'(fault_cycle));
      done_run = m_done ? done_run + 1 : 0;
      #1;
      check_eq("start_event", cyc, {7'd0, start_event}, {7'd0, e_start});
      check_eq("test_expr",   cyc, {7'd0, test_expr},   {7'd0, e_test});
      check_eq("in_window",   cyc, {7'd0, in_window},   {7'd0, e_win});
      check_eq("expect_fire", cyc, {7'd0, expect_fire}, {7'd0, e_fire});
      check_eq("win_count",   cyc, win_count,           8'(m_cnt));
      check_eq("done",        cyc, {7'd0, done},        {7'd0, e_done});
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
